// File: rtl/adec_ws.sv
// Address decoder with prioritised chip-select regions, per-region wait states
// and a writable bank register that maps a 16-bit CPU window into physical space.
module adec_ws #(
    parameter int                       NCS           = 5,
    parameter int                       ADDR_W        = 16,
    parameter int                       BANK_W        = 3,
    parameter logic [NCS*ADDR_W-1:0]    REGION_BASE   = {16'h0000, 16'hDC20, 16'hDC10, 16'hDC00, 16'hD400},
    parameter logic [NCS*ADDR_W-1:0]    REGION_MASK   = {16'h0000, 16'hFFF0, 16'hFFF0, 16'hFC00, 16'hFC00},
    parameter logic [NCS*4-1:0]         REGION_WS     = {4'd0, 4'd2, 4'd1, 4'd1, 4'd0},
    parameter logic [ADDR_W-1:0]        BANK_REG_ADDR = 16'hDF00,
    parameter logic [ADDR_W-1:0]        WIN_BASE      = 16'h8000,
    parameter logic [ADDR_W-1:0]        WIN_MASK      = 16'hC000
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       rw,
    input  logic                       cycle_start,
    input  logic [7:0]                 data_in,
    output logic [NCS-1:0]             cs_n,
    output logic                       rdy,
    output logic [ADDR_W+BANK_W-1:0]   phys_addr,
    output logic [BANK_W-1:0]          bank
);

    localparam int IDX_W = (NCS > 1) ? $clog2(NCS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       sel_vld_q, sel_vld_d;
    logic [IDX_W-1:0]           sel_idx_q, sel_idx_d;
    logic                       hit_q, hit_d;
    logic                       rw_q, rw_d;
    logic [ADDR_W+BANK_W-1:0]   phys_d;
    logic [BANK_W-1:0]          bank_d;
    logic [NCS-1:0]             cs_n_d;
    logic                       rdy_d;

    logic                       match_vld;
    logic [IDX_W-1:0]           match_idx;
    logic [3:0]                 match_ws;
    logic                       bank_hit;

    // Walk from the top index down so the lowest matching region is the one kept.
    always_comb begin
        match_vld = 1'b0;
        match_idx = '0;
        match_ws  = '0;
        for (int i = NCS - 1; i >= 0; i--) begin
            if ((addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                match_vld = 1'b1;
                match_idx = IDX_W'(i);
                match_ws  = REGION_WS[i*4 +: 4];
            end
        end
        bank_hit = (addr == BANK_REG_ADDR);
        if (bank_hit) begin
            match_vld = 1'b0;
            match_ws  = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_vld_d = sel_vld_q;
        sel_idx_d = sel_idx_q;
        hit_d     = hit_q;
        rw_d      = rw_q;
        phys_d    = phys_addr;
        bank_d    = bank;

        case (state_q)
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                // ACCESS behaves like IDLE for decode, which gives back-to-back cycles.
                if (state_q == ACCESS && hit_q && !rw_q) begin
                    bank_d = data_in[BANK_W-1:0];
                end
                if (cycle_start) begin
                    sel_vld_d = match_vld;
                    sel_idx_d = match_idx;
                    hit_d     = bank_hit;
                    rw_d      = rw;
                    phys_d    = ((addr & WIN_MASK) == WIN_BASE) ? {bank, addr} : {BANK_W'(0), addr};
                    if (match_ws != 4'd0) begin
                        state_d = WAIT;
                        cnt_d   = match_ws;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d   = IDLE;
                    sel_vld_d = 1'b0;
                    hit_d     = 1'b0;
                end
            end
        endcase

        cs_n_d = '1;
        if (state_d != IDLE && sel_vld_d) begin
            cs_n_d[sel_idx_d] = 1'b0;
        end
        rdy_d = (state_d != WAIT);
    end

    // Control and output registers: outputs are registered from the next-state view.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_vld_q <= 1'b0;
            hit_q     <= 1'b0;
            cs_n      <= '1;
            rdy       <= 1'b1;
            phys_addr <= '0;
            bank      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_vld_q <= sel_vld_d;
            hit_q     <= hit_d;
            cs_n      <= cs_n_d;
            rdy       <= rdy_d;
            phys_addr <= phys_d;
            bank      <= bank_d;
        end
    end

    // Only consulted while sel_vld_q/hit_q qualify them, so no reset needed.
    always_ff @(posedge clock) begin
        sel_idx_q <= sel_idx_d;
        rw_q      <= rw_d;
    end

endmodule

// File: tb/tb_adec_ws.sv
// Self-checking bench for adec_ws: transaction-level reference model compared
// every cycle, plus directed literal checks of decode, wait states and banking.
module tb_adec_ws;

    localparam int NCS = 5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] addr = '0;
    logic        rw = 1'b1;
    logic        cycle_start = 1'b0;
    logic [7:0]  data_in = '0;
    logic [4:0]  cs_n;
    logic        rdy;
    logic [18:0] phys_addr;
    logic [2:0]  bank;

    always #5 clock = ~clock;

    // VIA1 narrowed to a 16-byte window so the VIA2 and UART regions are reachable.
    adec_ws #(
        .REGION_MASK({16'h0000, 16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFC00})
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .addr       (addr),
        .rw         (rw),
        .cycle_start(cycle_start),
        .data_in    (data_in),
        .cs_n       (cs_n),
        .rdy        (rdy),
        .phys_addr  (phys_addr),
        .bank       (bank)
    );

    localparam logic [15:0] M_BASE [NCS] = '{16'hD400, 16'hDC00, 16'hDC10, 16'hDC20, 16'h0000};
    localparam logic [15:0] M_MASK [NCS] = '{16'hFC00, 16'hFFF0, 16'hFFF0, 16'hFFF0, 16'h0000};
    localparam int          M_WS   [NCS] = '{0, 1, 1, 2, 0};

    int          n_checks = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    // Reference model: one transaction in flight, described by start cycle, length and target.
    int          cyc, busy_until, bw_cyc, t_start, t_ws, t_idx;
    logic [2:0]  m_bank;
    logic [18:0] m_phys;
    logic [4:0]  exp_cs;
    logic        exp_rdy;
    logic [18:0] exp_phys;
    logic [2:0]  exp_bank;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic decode(input logic [15:0] a, output int idx, output int ws, output bit bh);
        idx = -1;
        ws  = 0;
        bh  = (a == 16'hDF00);
        if (!bh) begin
            for (int i = 0; i < NCS; i++) begin
                if ((a & M_MASK[i]) == M_BASE[i]) begin
                    idx = i;
                    ws  = M_WS[i];
                    break;
                end
            end
        end
    endtask

    task automatic model_reset();
        cyc = 0; busy_until = 0; bw_cyc = -1;
        t_start = -1; t_ws = 0; t_idx = -1;
        m_bank = '0; m_phys = '0;
        exp_cs = 5'h1F; exp_rdy = 1'b1; exp_phys = '0; exp_bank = '0;
    endtask

    // Called once per cycle with that cycle's inputs; yields outputs of the next cycle.
    task automatic model_step();
        int idx, ws, n;
        bit bh;
        logic [2:0] nb;
        nb = m_bank;
        if (bw_cyc == cyc) nb = data_in[2:0];
        if (cycle_start && cyc >= busy_until) begin
            decode(addr, idx, ws, bh);
            t_start = cyc; t_ws = ws; t_idx = idx;
            busy_until = cyc + ws + 1;
            m_phys = ((addr & 16'hC000) == 16'h8000) ? {m_bank, addr} : {3'b000, addr};
            if (bh && !rw) bw_cyc = busy_until;
        end
        m_bank = nb;
        n = cyc + 1;
        exp_cs  = 5'h1F;
        exp_rdy = 1'b1;
        if (t_start >= 0 && n > t_start && n <= t_start + t_ws + 1) begin
            if (t_idx >= 0) exp_cs[t_idx] = 1'b0;
            exp_rdy = (n == t_start + t_ws + 1);
        end
        exp_phys = m_phys;
        exp_bank = m_bank;
        cyc++;
    endtask

    always @(posedge clock) begin
        #1;
        if (chk_en) begin
            check("cs_n", 32'(cs_n), 32'(exp_cs));
            check("rdy", 32'(rdy), 32'(exp_rdy));
            check("phys_addr", 32'(phys_addr), 32'(exp_phys));
            check("bank", 32'(bank), 32'(exp_bank));
        end
    end

    task automatic step(input logic s, input logic [15:0] a, input logic r, input logic [7:0] d);
        @(negedge clock);
        cycle_start = s; addr = a; rw = r; data_in = d;
        model_step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        step(1'b0, addr, rw, data_in);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cycle_start = 1'b0;
        model_reset();
        model_step();
        chk_en = 1'b1;
        @(posedge clock);
        #2;
    endtask

    // Run one read cycle and measure how long rdy stays low and the select stays asserted.
    task automatic measure(input logic [15:0] a, input logic [4:0] cs_exp, input int rdy_low_exp, input string nm);
        int rl, cl;
        step(1'b1, a, 1'b1, 8'h00);
        check({nm, "_first_cs"}, 32'(cs_n), 32'(cs_exp));
        rl = 0;
        cl = 0;
        for (int k = 0; k < 8; k++) begin
            if (!rdy) rl++;
            if (cs_n != 5'h1F) cl++;
            if (cs_n == 5'h1F && rdy) break;
            idle();
        end
        check({nm, "_rdy_low"}, 32'(rl), 32'(rdy_low_exp));
        check({nm, "_cs_low"}, 32'(cl), (cs_exp == 5'h1F) ? 32'd0 : 32'(rdy_low_exp + 1));
    endtask

    initial begin
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_cs_n", 32'(cs_n), 32'h1F);
        check("rst_rdy", 32'(rdy), 32'h1);
        check("rst_bank", 32'(bank), 32'h0);
        check("rst_phys", 32'(phys_addr), 32'h0);
        repeat (2) @(posedge clock);
        release_reset();

        // Decode sweep with wait-state lengths
        measure(16'hC000, 5'b01111, 0, "ram");
        measure(16'hD400, 5'b11110, 0, "sid");
        measure(16'hDC00, 5'b11101, 1, "via1");
        measure(16'hDC10, 5'b11011, 1, "via2");
        measure(16'hDC20, 5'b10111, 2, "uart");
        measure(16'hDF00, 5'b11111, 0, "bankreg_rd");

        // Banking: data must still be present at the end of the ACCESS cycle
        step(1'b1, 16'hDF00, 1'b0, 8'h05);
        check("bankwr_cs", 32'(cs_n), 32'h1F);
        idle();
        check("bank_after_wr", 32'(bank), 32'h5);
        step(1'b1, 16'h9234, 1'b1, 8'h00);
        check("phys_banked", 32'(phys_addr), 32'({3'd5, 16'h9234}));
        idle();
        step(1'b1, 16'h1234, 1'b1, 8'h00);
        check("phys_unbanked", 32'(phys_addr), 32'h01234);
        idle();

        // cycle_start during WAIT ignored; in ACCESS it starts the next cycle
        step(1'b1, 16'hDC20, 1'b1, 8'h00);
        check("ign_w1_cs", 32'(cs_n), 32'b10111);
        step(1'b1, 16'hD400, 1'b1, 8'h00);
        check("ign_w2_cs", 32'(cs_n), 32'b10111);
        check("ign_w2_rdy", 32'(rdy), 32'h0);
        step(1'b0, 16'hD400, 1'b1, 8'h00);
        check("ign_acc_cs", 32'(cs_n), 32'b10111);
        check("ign_acc_rdy", 32'(rdy), 32'h1);
        step(1'b1, 16'hD400, 1'b1, 8'h00);
        check("b2b_cs", 32'(cs_n), 32'b11110);
        idle();
        check("b2b_done_cs", 32'(cs_n), 32'h1F);

        // Asynchronous reset in the middle of a UART wait
        step(1'b1, 16'hDC20, 1'b1, 8'h00);
        check("pre_rst_rdy", 32'(rdy), 32'h0);
        chk_en = 1'b0;
        reset_n = 1'b0;
        cycle_start = 1'b0;
        #1;
        check("midwait_rst_cs", 32'(cs_n), 32'h1F);
        check("midwait_rst_rdy", 32'(rdy), 32'h1);
        check("midwait_rst_bank", 32'(bank), 32'h0);
        repeat (2) @(posedge clock);
        release_reset();

        // Randomised traffic against the reference model
        for (int n = 0; n < 2000; n++) begin
            logic [15:0] r16;
            logic [15:0] a;
            r16 = 16'($urandom);
            case ($urandom_range(0, 7))
                0: a = 16'hC000 | {4'h0, r16[11:0]};
                1: a = 16'hD400 | {6'h0, r16[9:0]};
                2: a = 16'hDC00 | {12'h0, r16[3:0]};
                3: a = 16'hDC10 | {12'h0, r16[3:0]};
                4: a = 16'hDC20 | {12'h0, r16[3:0]};
                5: a = 16'hDF00;
                6: a = 16'h8000 | {2'b00, r16[13:0]};
                default: a = r16;
            endcase
            step(($urandom_range(0, 2) == 0), a, 1'($urandom_range(0, 1)), 8'($urandom));
        end
        cycle_start = 1'b0;
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
